hazard_ctrl_md: RTL and testbench

- Parametrised successor to the five-stage MIPS hazard controller (F/D/E/M/W).
- Generates forwarding-mux selects and the stall/flush controls for PC, D, E and M.
- Owns the mult/div busy timer internally, so the HI/LO unit no longer supplies start/busy.
- Accepts an exception/interrupt flush request from M, which overrides all stalls.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_ctrl_md_md_busy_timer.sv | 52 +++++
 rtl/hazard_ctrl_md.sv | 116 +++++++++++
 tb/tb_hazard_ctrl_md.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and default latencies for the hazard controller and its
// mult/div busy timer.
package hazard_pkg;

    // D-stage forward selects
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_M  = 2'd1;
    localparam logic [1:0] FWD_E  = 2'd2;

    // E-stage forward selects (W-source encodings)
    localparam logic [1:0] FWDX_NONE = 2'd0;
    localparam logic [1:0] FWDX_W    = 2'd1;
    localparam logic [1:0] FWDX_M    = 2'd2;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/hazard_ctrl_md_md_busy_timer.sv
// Mult/div occupancy timer: holds busy for LAT cycles after an accepted start.
module md_busy_timer
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    md_state_t         state_reg;
    logic [CW-1:0]     cnt_reg;

    // A start seen while BUSY is ignored; the counter is never reloaded mid-op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= MD_IDLE;
            cnt_reg   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state_reg)
                MD_IDLE: begin
                    if (start) begin
                        state_reg <= MD_BUSY;
                        cnt_reg   <= is_div ? CW'(DIV_LAT - 1) : CW'(MULT_LAT - 1);
                        busy      <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (cnt_reg == '0) begin
                        state_reg <= MD_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                default: begin
                    state_reg <= MD_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_ctrl_md.sv
// Five-stage hazard controller with forwarding, stall/flush and internal mult/div timer.
// Optional stall performance counter is enabled by defining HAZARD_PERF_EN.
module hazard_ctrl_md
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int TW       = 2,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs_D,
    input  logic [REG_AW-1:0] rt_D,
    input  logic [REG_AW-1:0] rs_E,
    input  logic [REG_AW-1:0] rt_E,
    input  logic [REG_AW-1:0] rt_M,
    input  logic [REG_AW-1:0] A3_E,
    input  logic [REG_AW-1:0] A3_M,
    input  logic [REG_AW-1:0] A3_W,
    input  logic [TW-1:0]     Tuse_rs,
    input  logic [TW-1:0]     Tuse_rt,
    input  logic [TW-1:0]     Tnew_E,
    input  logic [TW-1:0]     Tnew_M,
    input  logic              md_start_E,
    input  logic              md_div_E,
    input  logic              md_use_D,
    input  logic              flush_req,
    output logic [1:0]        MF_RD1_Sel,
    output logic [1:0]        MF_RD2_Sel,
    output logic [1:0]        MF_ALUA_Sel,
    output logic [1:0]        MF_ALUB_Sel,
    output logic              MF_DMWD_Sel,
    output logic              PC_en,
    output logic              D_en,
    output logic              D_clr,
    output logic              E_clr,
    output logic              M_clr,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [REG_AW-1:0] src_d  [2];
    logic [TW-1:0]     tuse_d [2];
    logic [REG_AW-1:0] src_e  [2];
    logic [1:0]        fwd_d  [2];
    logic [1:0]        fwd_e  [2];
    logic [1:0]        data_stall_src;

    assign src_d[0]  = rs_D;
    assign src_d[1]  = rt_D;
    assign tuse_d[0] = Tuse_rs;
    assign tuse_d[1] = Tuse_rt;
    assign src_e[0]  = rs_E;
    assign src_e[1]  = rt_E;

    // Register 0 is hard-wired, so it never matches a producer.
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        logic hit_e, hit_m, hit_w_e, hit_m_e;
        assign hit_e   = (src_d[gi] != '0) && (src_d[gi] == A3_E);
        assign hit_m   = (src_d[gi] != '0) && (src_d[gi] == A3_M);
        assign hit_m_e = (src_e[gi] != '0) && (src_e[gi] == A3_M);
        assign hit_w_e = (src_e[gi] != '0) && (src_e[gi] == A3_W);

        assign fwd_d[gi] = hit_e ? FWD_E : (hit_m ? FWD_M : FWD_RF);
        assign fwd_e[gi] = hit_m_e ? FWDX_M : (hit_w_e ? FWDX_W : FWDX_NONE);

        assign data_stall_src[gi] = (hit_e && (tuse_d[gi] < Tnew_E)) ||
                                    (hit_m && (tuse_d[gi] < Tnew_M));
    end

    assign MF_RD1_Sel  = fwd_d[0];
    assign MF_RD2_Sel  = fwd_d[1];
    assign MF_ALUA_Sel = fwd_e[0];
    assign MF_ALUB_Sel = fwd_e[1];
    assign MF_DMWD_Sel = (rt_M != '0) && (rt_M == A3_W);

    md_busy_timer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start_E & ~flush_req),
        .is_div (md_div_E),
        .busy   (md_busy)
    );

    logic stall;
    assign stall = (|data_stall_src) | (md_use_D & (md_start_E | md_busy));

    // A taken exception flushes everything and lets the PC move to the handler.
    assign PC_en = flush_req | ~stall;
    assign D_en  = flush_req | ~stall;
    assign D_clr = flush_req;
    assign E_clr = flush_req | stall;
    assign M_clr = flush_req;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= '0;
        end else if (stall && !flush_req && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_reg;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_md.sv
// Directed testbench for hazard_ctrl_md; a second instance with CNT_W=3
// exercises counter saturation.
module tb_hazard_ctrl_md;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_D, rt_D, rs_E, rt_E, rt_M, A3_E, A3_M, A3_W;
    logic [1:0] Tuse_rs, Tuse_rt, Tnew_E, Tnew_M;
    logic       md_start_E, md_div_E, md_use_D, flush_req;
    logic [1:0] MF_RD1_Sel, MF_RD2_Sel, MF_ALUA_Sel, MF_ALUB_Sel;
    logic       MF_DMWD_Sel, PC_en, D_en, D_clr, E_clr, M_clr, md_busy;
    logic [15:0] stall_cnt;
    logic [1:0] s3_rd1, s3_rd2, s3_alua, s3_alub;
    logic       s3_dmwd, s3_pc, s3_d, s3_dclr, s3_eclr, s3_mclr, s3_busy;
    logic [2:0] stall_cnt3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_md dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E), .rt_M(rt_M),
        .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W),
        .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt), .Tnew_E(Tnew_E), .Tnew_M(Tnew_M),
        .md_start_E(md_start_E), .md_div_E(md_div_E), .md_use_D(md_use_D),
        .flush_req(flush_req),
        .MF_RD1_Sel(MF_RD1_Sel), .MF_RD2_Sel(MF_RD2_Sel),
        .MF_ALUA_Sel(MF_ALUA_Sel), .MF_ALUB_Sel(MF_ALUB_Sel),
        .MF_DMWD_Sel(MF_DMWD_Sel), .PC_en(PC_en), .D_en(D_en),
        .D_clr(D_clr), .E_clr(E_clr), .M_clr(M_clr),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    hazard_ctrl_md #(.CNT_W(3)) dut3 (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E), .rt_M(rt_M),
        .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W),
        .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt), .Tnew_E(Tnew_E), .Tnew_M(Tnew_M),
        .md_start_E(md_start_E), .md_div_E(md_div_E), .md_use_D(md_use_D),
        .flush_req(flush_req),
        .MF_RD1_Sel(s3_rd1), .MF_RD2_Sel(s3_rd2),
        .MF_ALUA_Sel(s3_alua), .MF_ALUB_Sel(s3_alub),
        .MF_DMWD_Sel(s3_dmwd), .PC_en(s3_pc), .D_en(s3_d),
        .D_clr(s3_dclr), .E_clr(s3_eclr), .M_clr(s3_mclr),
        .md_busy(s3_busy), .stall_cnt(stall_cnt3)
    );

    task automatic clear_inputs();
        rs_D = 0; rt_D = 0; rs_E = 0; rt_E = 0; rt_M = 0;
        A3_E = 0; A3_M = 0; A3_W = 0;
        Tuse_rs = 0; Tuse_rt = 0; Tnew_E = 0; Tnew_M = 0;
        md_start_E = 0; md_div_E = 0; md_use_D = 0; flush_req = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        #1;
        checks++;
        if (md_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", md_busy);
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt);
        end
        // combinational path stays live while reset is held
        rs_D = 5'd8; A3_E = 5'd8;
        #1;
        checks++;
        if (MF_RD1_Sel !== 2'd2) begin
            errors++; $display("FAIL reset_comb_fwd: got %0d expected 2", MF_RD1_Sel);
        end
        tick();
        reset = 1'b1;
        clear_inputs();
        #1;
        $display("test_reset done");
    endtask

    task automatic test_forwarding();
        clear_inputs();
        A3_E = 5'd8; A3_M = 5'd8; rs_D = 5'd8; rt_D = 5'd8;
        #1;
        checks++;
        if (MF_RD1_Sel !== 2'd2) begin
            errors++; $display("FAIL fwd_rd1_nearest: got %0d expected 2", MF_RD1_Sel);
        end
        checks++;
        if (MF_RD2_Sel !== 2'd2) begin
            errors++; $display("FAIL fwd_rd2_nearest: got %0d expected 2", MF_RD2_Sel);
        end
        A3_E = 5'd0; A3_M = 5'd0; rs_D = 5'd0; rt_D = 5'd0;
        #1;
        checks++;
        if (MF_RD1_Sel !== 2'd0) begin
            errors++; $display("FAIL fwd_rd1_zero: got %0d expected 0", MF_RD1_Sel);
        end
        A3_E = 5'd4; A3_M = 5'd3; rs_D = 5'd3; rt_D = 5'd4;
        #1;
        checks++;
        if (MF_RD1_Sel !== 2'd1) begin
            errors++; $display("FAIL fwd_rd1_m: got %0d expected 1", MF_RD1_Sel);
        end
        checks++;
        if (MF_RD2_Sel !== 2'd2) begin
            errors++; $display("FAIL fwd_rd2_e: got %0d expected 2", MF_RD2_Sel);
        end
        clear_inputs();
        rs_E = 5'd6; rt_E = 5'd7; A3_M = 5'd6; A3_W = 5'd7;
        #1;
        checks++;
        if (MF_ALUA_Sel !== 2'd2) begin
            errors++; $display("FAIL fwd_alua_m: got %0d expected 2", MF_ALUA_Sel);
        end
        checks++;
        if (MF_ALUB_Sel !== 2'd1) begin
            errors++; $display("FAIL fwd_alub_w: got %0d expected 1", MF_ALUB_Sel);
        end
        A3_W = 5'd6; rt_E = 5'd2;
        #1;
        checks++;
        if (MF_ALUA_Sel !== 2'd2) begin
            errors++; $display("FAIL fwd_alua_nearest: got %0d expected 2", MF_ALUA_Sel);
        end
        checks++;
        if (MF_ALUB_Sel !== 2'd0) begin
            errors++; $display("FAIL fwd_alub_none: got %0d expected 0", MF_ALUB_Sel);
        end
        A3_M = 5'd0;
        #1;
        checks++;
        if (MF_ALUA_Sel !== 2'd1) begin
            errors++; $display("FAIL fwd_alua_w: got %0d expected 1", MF_ALUA_Sel);
        end
        clear_inputs();
        rt_M = 5'd9; A3_W = 5'd9;
        #1;
        checks++;
        if (MF_DMWD_Sel !== 1'b1) begin
            errors++; $display("FAIL fwd_dmwd_w: got %b expected 1", MF_DMWD_Sel);
        end
        rt_M = 5'd0; A3_W = 5'd0;
        #1;
        checks++;
        if (MF_DMWD_Sel !== 1'b0) begin
            errors++; $display("FAIL fwd_dmwd_zero: got %b expected 0", MF_DMWD_Sel);
        end
        clear_inputs();
        $display("test_forwarding done");
    endtask

    task automatic test_load_use();
        clear_inputs();
        A3_E = 5'd5; Tnew_E = 2'd2; rs_D = 5'd5; Tuse_rs = 2'd1;
        #1;
        checks++;
        if ({PC_en, D_en, E_clr, D_clr, M_clr} !== 5'b00100) begin
            errors++; $display("FAIL loaduse_stall: got %b expected 00100", {PC_en, D_en, E_clr, D_clr, M_clr});
        end
        Tuse_rs = 2'd2;
        #1;
        checks++;
        if ({PC_en, D_en, E_clr} !== 3'b110) begin
            errors++; $display("FAIL loaduse_nostall: got %b expected 110", {PC_en, D_en, E_clr});
        end
        checks++;
        if (MF_RD1_Sel !== 2'd2) begin
            errors++; $display("FAIL loaduse_fwd: got %0d expected 2", MF_RD1_Sel);
        end
        clear_inputs();
        A3_M = 5'd12; Tnew_M = 2'd1; rt_D = 5'd12; Tuse_rt = 2'd0;
        #1;
        checks++;
        if (PC_en !== 1'b0) begin
            errors++; $display("FAIL loaduse_rt_m: got %b expected 0", PC_en);
        end
        clear_inputs();
        A3_E = 5'd0; rs_D = 5'd0; Tnew_E = 2'd3;
        #1;
        checks++;
        if (PC_en !== 1'b1) begin
            errors++; $display("FAIL loaduse_zero_reg: got %b expected 1", PC_en);
        end
        clear_inputs();
        $display("test_load_use done");
    endtask

    task automatic test_div_mflo();
        do_reset();
        md_start_E = 1'b1; md_div_E = 1'b1; md_use_D = 1'b1;
        #1;
        checks++;
        if ({PC_en, md_busy} !== 2'b00) begin
            errors++; $display("FAIL div_issue: got %b expected 00", {PC_en, md_busy});
        end
        tick();
        md_start_E = 1'b0; md_div_E = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({md_busy, PC_en, E_clr} !== 3'b101) begin
                errors++; $display("FAIL div_busy_cycle%0d: got %b expected 101", i, {md_busy, PC_en, E_clr});
            end
            tick();
        end
        checks++;
        if ({md_busy, PC_en} !== 2'b01) begin
            errors++; $display("FAIL div_release: got %b expected 01", {md_busy, PC_en});
        end
        clear_inputs();
        $display("test_div_mflo done");
    endtask

    task automatic test_flush();
        do_reset();
        A3_E = 5'd5; Tnew_E = 2'd2; rs_D = 5'd5; Tuse_rs = 2'd1; flush_req = 1'b1;
        #1;
        checks++;
        if ({PC_en, D_en, D_clr, E_clr, M_clr} !== 5'b11111) begin
            errors++; $display("FAIL flush_override: got %b expected 11111", {PC_en, D_en, D_clr, E_clr, M_clr});
        end
        tick();
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++; $display("FAIL flush_cnt_hold: got %0d expected 0", stall_cnt);
        end
        flush_req = 1'b0;
        #1;
        checks++;
        if ({PC_en, E_clr, D_clr, M_clr} !== 4'b0100) begin
            errors++; $display("FAIL flush_release: got %b expected 0100", {PC_en, E_clr, D_clr, M_clr});
        end
        tick();
        checks++;
        if (stall_cnt !== 16'(PERF ? 1 : 0)) begin
            errors++; $display("FAIL flush_cnt_after: got %0d expected %0d", stall_cnt, PERF ? 1 : 0);
        end
        clear_inputs();
        md_start_E = 1'b1; flush_req = 1'b1;
        tick();
        clear_inputs();
        #1;
        checks++;
        if (md_busy !== 1'b0) begin
            errors++; $display("FAIL flush_md_start: got %b expected 0", md_busy);
        end
        tick();
        checks++;
        if (md_busy !== 1'b0) begin
            errors++; $display("FAIL flush_md_start_later: got %b expected 0", md_busy);
        end
        $display("test_flush done");
    endtask

    task automatic test_reset_mid_mult();
        do_reset();
        md_start_E = 1'b1; md_div_E = 1'b0;
        tick();
        md_start_E = 1'b0;
        tick();
        tick();
        checks++;
        if (md_busy !== 1'b1) begin
            errors++; $display("FAIL mult_busy_before_reset: got %b expected 1", md_busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (md_busy !== 1'b0) begin
            errors++; $display("FAIL mult_reset_async: got %b expected 0", md_busy);
        end
        tick();
        reset = 1'b1;
        md_start_E = 1'b1;
        tick();
        md_start_E = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (md_busy !== 1'b1) begin
                errors++; $display("FAIL mult_busy_cycle%0d: got %b expected 1", i, md_busy);
            end
            tick();
        end
        checks++;
        if (md_busy !== 1'b0) begin
            errors++; $display("FAIL mult_done: got %b expected 0", md_busy);
        end
        clear_inputs();
        $display("test_reset_mid_mult done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        // second start during BUSY must not extend the mult
        md_start_E = 1'b1;
        tick();
        tick();
        tick();
        md_start_E = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (md_busy !== 1'b0) begin
            errors++; $display("FAIL b2b_no_reload: got %b expected 0", md_busy);
        end
        clear_inputs();
        $display("test_back_to_back done");
    endtask

    task automatic test_perf_counter();
        do_reset();
        A3_E = 5'd5; Tnew_E = 2'd2; rs_D = 5'd5; Tuse_rs = 2'd1;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (stall_cnt !== 16'(PERF ? 7 : 0)) begin
            errors++; $display("FAIL perf_cnt7: got %0d expected %0d", stall_cnt, PERF ? 7 : 0);
        end
        tick();
        tick();
        checks++;
        if (stall_cnt !== 16'(PERF ? 9 : 0)) begin
            errors++; $display("FAIL perf_cnt9: got %0d expected %0d", stall_cnt, PERF ? 9 : 0);
        end
        checks++;
        if (stall_cnt3 !== 3'(PERF ? 7 : 0)) begin
            errors++; $display("FAIL perf_cnt_sat: got %0d expected %0d", stall_cnt3, PERF ? 7 : 0);
        end
        clear_inputs();
        $display("test_perf_counter done");
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #2;
        test_reset();
        test_forwarding();
        test_load_use();
        test_div_mflo();
        test_flush();
        test_reset_mid_mult();
        test_back_to_back();
        test_perf_counter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
